// File: rtl/sha256_pad.sv
// SHA-256 message padder: turns a tlast-delimited byte stream into whole 512-bit
// blocks carrying the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_pad #(
   parameter int unsigned AXI_DATA_BITS = 512,
   parameter int unsigned ID_BITS       = 1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       axis_sink_tvalid,
   output logic                       axis_sink_tready,
   input  logic [AXI_DATA_BITS-1:0]   axis_sink_tdata,
   input  logic [AXI_DATA_BITS/8-1:0] axis_sink_tkeep,
   input  logic                       axis_sink_tlast,
   input  logic [ID_BITS-1:0]         axis_sink_tid,
   output logic                       axis_src_tvalid,
   input  logic                       axis_src_tready,
   output logic [AXI_DATA_BITS-1:0]   axis_src_tdata,
   output logic [AXI_DATA_BITS/8-1:0] axis_src_tkeep,
   output logic                       axis_src_tlast,
   output logic [ID_BITS-1:0]         axis_src_tid,
   output logic [31:0]                msg_cnt
);

   generate
      if (AXI_DATA_BITS != 512) begin : g_bad_width
         $error("sha256_pad supports only AXI_DATA_BITS = 512");
      end
   endgenerate

   typedef enum logic [1:0] {ST_DATA, ST_PAD80, ST_LEN} state_t;

   state_t                     r_state, w_state_nxt;
   logic                       r_o_valid, w_o_valid_nxt;
   logic [AXI_DATA_BITS-1:0]   r_o_data, w_o_data_nxt;
   logic                       r_o_last, w_o_last_nxt;
   logic [ID_BITS-1:0]         r_o_tid, w_o_tid_nxt;
   logic [ID_BITS-1:0]         r_tid_lat, w_tid_lat_nxt;
   logic [63:0]                r_byte_cnt, w_byte_cnt_nxt;
   logic [63:0]                r_len_bits, w_len_bits_nxt;
   logic [31:0]                r_msg_cnt;

   logic                       w_load;
   logic                       w_accept;
   logic                       w_run;
   logic [6:0]                 w_n;
   logic [63:0]                w_len;
   logic [AXI_DATA_BITS-1:0]   w_last_data;
   logic [AXI_DATA_BITS-1:0]   w_gen_data;

   // Length occupies lanes 56..63, most significant byte in lane 56.
   function automatic logic [511:0] f_len_lanes(input logic [63:0] len);
      logic [511:0] res;
      res = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         res[8*(56+k) +: 8] = len[8*(7-k) +: 8];
      end
      return res;
   endfunction

   assign w_load           = !r_o_valid || axis_src_tready;
   assign axis_sink_tready = aresetn && w_load && (r_state == ST_DATA);
   assign w_accept         = axis_sink_tvalid && axis_sink_tready;

   assign axis_src_tvalid  = r_o_valid;
   assign axis_src_tdata   = r_o_data;
   assign axis_src_tkeep   = '1;
   assign axis_src_tlast   = r_o_last;
   assign axis_src_tid     = r_o_tid;
   assign msg_cnt          = r_msg_cnt;

   always_comb begin
      w_n   = '0;
      w_run = 1'b1;
      for (int unsigned i = 0; i < 64; i++) begin
         if (w_run && axis_sink_tkeep[i]) w_n = w_n + 7'd1;
         else                             w_run = 1'b0;
      end
      w_len = (r_byte_cnt + 64'(w_n)) << 3;

      w_last_data = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (7'(i) < w_n)       w_last_data[8*i +: 8] = axis_sink_tdata[8*i +: 8];
         else if (7'(i) == w_n) w_last_data[8*i +: 8] = 8'h80;
      end
      if (w_n <= 7'd55) w_last_data = w_last_data | f_len_lanes(w_len);

      w_gen_data = f_len_lanes(r_len_bits);
      if (r_state == ST_PAD80) w_gen_data[7:0] = 8'h80;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_o_valid_nxt  = r_o_valid;
      w_o_data_nxt   = r_o_data;
      w_o_last_nxt   = r_o_last;
      w_o_tid_nxt    = r_o_tid;
      w_tid_lat_nxt  = r_tid_lat;
      w_byte_cnt_nxt = r_byte_cnt;
      w_len_bits_nxt = r_len_bits;
      if (w_load) begin
         w_o_valid_nxt = 1'b0;
         case (r_state)
            ST_DATA: begin
               if (w_accept) begin
                  w_o_valid_nxt = 1'b1;
                  w_o_tid_nxt   = axis_sink_tid;
                  if (!axis_sink_tlast) begin
                     w_o_data_nxt   = axis_sink_tdata;
                     w_o_last_nxt   = 1'b0;
                     w_byte_cnt_nxt = r_byte_cnt + 64'd64;
                  end else begin
                     // byte_cnt is unused until the next message, so clear it here.
                     w_len_bits_nxt = w_len;
                     w_tid_lat_nxt  = axis_sink_tid;
                     w_byte_cnt_nxt = '0;
                     if (w_n <= 7'd55) begin
                        w_o_data_nxt = w_last_data;
                        w_o_last_nxt = 1'b1;
                     end else if (w_n <= 7'd63) begin
                        w_o_data_nxt = w_last_data;
                        w_o_last_nxt = 1'b0;
                        w_state_nxt  = ST_LEN;
                     end else begin
                        w_o_data_nxt = axis_sink_tdata;
                        w_o_last_nxt = 1'b0;
                        w_state_nxt  = ST_PAD80;
                     end
                  end
               end
            end
            ST_PAD80, ST_LEN: begin
               w_o_valid_nxt  = 1'b1;
               w_o_data_nxt   = w_gen_data;
               w_o_last_nxt   = 1'b1;
               w_o_tid_nxt    = r_tid_lat;
               w_byte_cnt_nxt = '0;
               w_state_nxt    = ST_DATA;
            end
            default: w_state_nxt = ST_DATA;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_DATA;
         r_o_valid  <= 1'b0;
         r_o_data   <= '0;
         r_o_last   <= 1'b0;
         r_o_tid    <= '0;
         r_tid_lat  <= '0;
         r_byte_cnt <= '0;
         r_len_bits <= '0;
         r_msg_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_o_valid  <= w_o_valid_nxt;
         r_o_data   <= w_o_data_nxt;
         r_o_last   <= w_o_last_nxt;
         r_o_tid    <= w_o_tid_nxt;
         r_tid_lat  <= w_tid_lat_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_len_bits <= w_len_bits_nxt;
         if (r_o_valid && r_o_last && axis_src_tready) r_msg_cnt <= r_msg_cnt + 32'd1;
      end
   end

endmodule
